// File: rtl/lsu_done_tracker_pkg.sv
// Shared sizing and types for the LSU done tracker.
// Holds the slot entry layout and the pointer helper.
package lsu_done_tracker_pkg;

  localparam int unsigned WF_PER_CU     = 40;
  localparam int unsigned LSU_TRK_DEPTH = 16;
  localparam int unsigned LSU_TAG_WIDTH = 4;
  localparam int unsigned WFID_WIDTH    = $clog2(WF_PER_CU);

  typedef logic [LSU_TAG_WIDTH-1:0] tag_t;
  typedef logic [WFID_WIDTH-1:0]    wfid_t;
  typedef logic [LSU_TAG_WIDTH:0]   cnt_t;

  typedef struct packed {
    logic  valid;
    logic  done;
    wfid_t wfid;
  } entry_t;

  // Pointers wrap 15 -> 0 by natural overflow of the tag width.
  function automatic tag_t tag_inc(input tag_t t);
    return t + tag_t'(1);
  endfunction

endpackage

// File: rtl/lsu_done_tracker_if.sv
// Issue/memory/retire signal bundle for the LSU done tracker.
// slave = tracker side, master = issue/memory side.
interface lsu_done_tracker_if;
  import lsu_done_tracker_pkg::*;

  logic  lsu_valid;
  wfid_t lsu_wfid;
  logic  lsu_full;
  logic  mem_req_valid;
  tag_t  mem_req_tag;
  logic  mem_ack;
  tag_t  mem_ack_tag;
  logic  lsu_done;
  wfid_t lsu_done_wfid;
  logic  overflow_err;

  modport slave (
    input  lsu_valid, lsu_wfid, mem_ack, mem_ack_tag,
    output lsu_full, mem_req_valid, mem_req_tag, lsu_done, lsu_done_wfid, overflow_err
  );

  modport master (
    output lsu_valid, lsu_wfid, mem_ack, mem_ack_tag,
    input  lsu_full, mem_req_valid, mem_req_tag, lsu_done, lsu_done_wfid, overflow_err
  );

endinterface

// File: rtl/lsu_done_tracker_decoder.sv
// 4-to-16 one-hot decoder with enable; all outputs low when disabled.
module decoder_4b_16b_en (
  input  logic        en,
  input  logic [3:0]  in,
  output logic [15:0] out
);

  always_comb begin
    out = '0;
    if (en) out[in] = 1'b1;
  end

endmodule

// File: rtl/lsu_done_tracker.sv
// In-order retirement tracker for LSU memory instructions: acks may arrive
// in any order, instructions retire from the head of a 16-slot age buffer.
module lsu_done_tracker
  import lsu_done_tracker_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  lsu_done_tracker_if.slave bus
);

  entry_t slot_q [LSU_TRK_DEPTH];
  entry_t slot_d [LSU_TRK_DEPTH];
  tag_t   wr_ptr_q, wr_ptr_d;
  tag_t   rd_ptr_q, rd_ptr_d;
  cnt_t   count_q, count_d;
  logic   overflow_q, overflow_d;

  logic [LSU_TRK_DEPTH-1:0] ack_hit;
  entry_t head;
  logic   full;
  logic   issue;
  logic   retire;

  decoder_4b_16b_en u_ack_dec (
    .en  (bus.mem_ack),
    .in  (bus.mem_ack_tag),
    .out (ack_hit)
  );

  assign head   = slot_q[rd_ptr_q];
  assign full   = (count_q == cnt_t'(LSU_TRK_DEPTH));
  assign issue  = bus.lsu_valid & ~full;
  assign retire = head.valid & head.done;

  always_comb begin
    for (int unsigned i = 0; i < LSU_TRK_DEPTH; i++) slot_d[i] = slot_q[i];
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (bus.lsu_valid & full);

    // Acks to slots that are not valid (stale or stray tags) are dropped.
    for (int unsigned i = 0; i < LSU_TRK_DEPTH; i++) begin
      if (ack_hit[i] && slot_q[i].valid) slot_d[i].done = 1'b1;
    end

    if (retire) begin
      slot_d[rd_ptr_q] = '0;
      rd_ptr_d         = tag_inc(rd_ptr_q);
    end

    // The issue slot is always free, so it never collides with an ack or retire.
    if (issue) begin
      slot_d[wr_ptr_q] = '{valid: 1'b1, done: 1'b0, wfid: bus.lsu_wfid};
      wr_ptr_d         = tag_inc(wr_ptr_q);
    end

    case ({issue, retire})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < LSU_TRK_DEPTH; i++) slot_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < LSU_TRK_DEPTH; i++) slot_q[i] <= slot_d[i];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // The request path is the only combinational input path; it is forced low in reset.
  assign bus.lsu_full      = full;
  assign bus.mem_req_valid = issue & rst;
  assign bus.mem_req_tag   = wr_ptr_q;
  assign bus.lsu_done      = retire;
  assign bus.lsu_done_wfid = retire ? head.wfid : '0;
  assign bus.overflow_err  = overflow_q;

endmodule

// File: tb/tb_lsu_done_tracker.sv
// Scoreboard bench for lsu_done_tracker: a queue-based in-order model
// predicts requests and retirements; a monitor compares them at negedge.
module tb_lsu_done_tracker;
  import lsu_done_tracker_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_done_tracker_if bus ();

  lsu_done_tracker dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  typedef struct {
    int tag;
    int wfid;
    bit done;
  } ref_t;

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  ref_t mdl[$];
  int   next_tag;
  bit   mdl_ovf;
  exp_t req_q[$];
  exp_t done_q[$];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected responses whenever the DUT presents one.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.mem_req_valid) begin
        if (req_q.size() == 0) check("req_unexpected", int'(bus.mem_req_valid), 0);
        else begin
          e = req_q.pop_front();
          check("req_tag", int'(bus.mem_req_tag), e.val);
          check("req_cycle", cyc, e.cyc);
        end
      end else if (req_q.size() > 0 && req_q[0].cyc <= cyc) begin
        e = req_q.pop_front();
        check("req_missing", int'(bus.mem_req_valid), 1);
      end

      if (bus.lsu_done) begin
        if (done_q.size() == 0) check("done_unexpected", int'(bus.lsu_done), 0);
        else begin
          e = done_q.pop_front();
          check("done_wfid", int'(bus.lsu_done_wfid), e.val);
          check("done_cycle", cyc, e.cyc);
        end
      end else begin
        check("idle_wfid", int'(bus.lsu_done_wfid), 0);
        if (done_q.size() > 0 && done_q[0].cyc <= cyc) begin
          e = done_q.pop_front();
          check("done_missing", int'(bus.lsu_done), 1);
        end
      end
    end
  end

  // One clock cycle of stimulus; called at posedge+1.
  task automatic step(input bit v, input int w, input bit a, input int at);
    bit   full_e;
    bit   retire_e;
    exp_t e;
    ref_t r;
    bus.lsu_valid   = v;
    bus.lsu_wfid    = wfid_t'(w);
    bus.mem_ack     = a;
    bus.mem_ack_tag = tag_t'(at);
    full_e   = (mdl.size() == 16);
    retire_e = (mdl.size() > 0) && mdl[0].done;
    if (v && !full_e) begin
      e.cyc = cyc; e.val = next_tag;
      req_q.push_back(e);
    end
    if (retire_e) begin
      e.cyc = cyc; e.val = mdl[0].wfid;
      done_q.push_back(e);
    end
    @(negedge clk);
    check("lsu_full", int'(bus.lsu_full), int'(full_e));
    check("overflow_err", int'(bus.overflow_err), int'(mdl_ovf));
    if (a) foreach (mdl[i]) if (mdl[i].tag == at) mdl[i].done = 1'b1;
    if (retire_e) void'(mdl.pop_front());
    if (v && !full_e) begin
      r.tag = next_tag; r.wfid = w; r.done = 1'b0;
      mdl.push_back(r);
      next_tag = (next_tag + 1) % 16;
    end
    if (v && full_e) mdl_ovf = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.lsu_valid   = 1'b1;
    bus.lsu_wfid    = 6'd17;
    bus.mem_ack     = 1'b0;
    bus.mem_ack_tag = '0;
    rst = 1'b0;
    #1;
    check("rst_lsu_full", int'(bus.lsu_full), 0);
    check("rst_lsu_done", int'(bus.lsu_done), 0);
    check("rst_done_wfid", int'(bus.lsu_done_wfid), 0);
    check("rst_req_valid", int'(bus.mem_req_valid), 0);
    check("rst_req_tag", int'(bus.mem_req_tag), 0);
    check("rst_overflow", int'(bus.overflow_err), 0);
    mdl.delete();
    req_q.delete();
    done_q.delete();
    next_tag = 0;
    mdl_ovf  = 1'b0;
    bus.lsu_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && mdl.size() > 0; n++) begin
      int t;
      t = mdl[0].tag;
      foreach (mdl[i]) if (!mdl[i].done) begin t = mdl[i].tag; break; end
      step(1'b0, 0, 1'b1, t);
    end
    step(1'b0, 0, 1'b0, 0);
    step(1'b0, 0, 1'b0, 0);
    check("model_drained", mdl.size(), 0);
  endtask

  initial begin
    #1 fork
      begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
      end
    join_none
  end

  initial begin
    rst = 1'b0;
    bus.lsu_valid = 1'b0; bus.lsu_wfid = '0; bus.mem_ack = 1'b0; bus.mem_ack_tag = '0;
    next_tag = 0; mdl_ovf = 1'b0;
    #1;
    do_reset();

    // Single instruction: issue, ack two cycles later, retire next cycle.
    step(1'b1, 5, 1'b0, 0);
    step(1'b0, 0, 1'b0, 0);
    step(1'b0, 0, 1'b1, 0);
    step(1'b0, 0, 1'b0, 0);
    step(1'b0, 0, 1'b0, 0);

    // Out-of-order acks still retire in issue order.
    step(1'b1, 1, 1'b0, 0);
    step(1'b1, 2, 1'b0, 0);
    step(1'b1, 3, 1'b0, 0);
    step(1'b0, 0, 1'b1, 3);
    step(1'b0, 0, 1'b1, 2);
    step(1'b0, 0, 1'b1, 1);
    for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b0, 0);

    // Minimum latency: ack the cycle after issue.
    step(1'b1, 39, 1'b0, 0);
    step(1'b0, 0, 1'b1, 4);
    step(1'b0, 0, 1'b0, 0);
    step(1'b0, 0, 1'b0, 0);

    // Fill, overflow, and slot freed by retire usable only the next cycle.
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, i + 20, 1'b0, 0);
    step(1'b1, 8, 1'b0, 0);
    step(1'b0, 0, 1'b1, 0);
    step(1'b1, 9, 1'b0, 0);
    step(1'b1, 10, 1'b0, 0);
    drain();

    // Stray ack to an empty slot, then reset with entries outstanding.
    do_reset();
    step(1'b1, 11, 1'b0, 0);
    step(1'b1, 12, 1'b1, 7);
    step(1'b0, 0, 1'b1, 7);
    step(1'b1, 13, 1'b1, 1);
    step(1'b1, 14, 1'b0, 0);
    do_reset();
    step(1'b0, 0, 1'b1, 1);
    step(1'b0, 0, 1'b1, 0);
    step(1'b1, 15, 1'b0, 0);
    step(1'b0, 0, 1'b1, 0);
    step(1'b0, 0, 1'b0, 0);
    step(1'b0, 0, 1'b0, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 500; n++) begin
      bit v, a;
      int w, at;
      v = ($urandom_range(9) < 6);
      w = $urandom_range(WF_PER_CU - 1);
      a = ($urandom_range(1) == 1);
      if (mdl.size() > 0 && $urandom_range(3) != 0) at = mdl[$urandom_range(mdl.size() - 1)].tag;
      else at = $urandom_range(15);
      step(v, w, a, at);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
